csr_access_ctrl: RTL
====================

Name: csr_access_ctrl

Overview:
Pipeline-side initiator for the CSR register file. It accepts one CSRRD/CSRWR/CSRXCHG request per transaction over a valid/ready handshake from the EX stage. It sequences a read phase and then an optional masked write phase onto the CSR file's csr_re/csr_num/csr_we/csr_wmask/csr_wvalue interface, and returns the old CSR value to the WB stage over a second valid/ready handshake. An exception/interrupt flush aborts any in-flight access.

Parameters:
CSR_NUM_W, 14, width of CSR number field from instruction; zero-extended to 32 on csr_num
REQ_PLV, 2'd0, privilege level required for CSR access (used only with CSR_ACC_PRIV_CHK_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  EX request valid
req_ready  out  1  controller can accept a request
req_op  in  2  00 CSRRD, 01 CSRWR, 10 CSRXCHG, 11 illegal
req_num  in  CSR_NUM_W  CSR number
req_wdata  in  32  rd value (write data)
req_wmask  in  32  rj value (mask, CSRXCHG only)
resp_valid  out  1  response valid
resp_ready  in  1  WB accepts response
resp_rdata  out  32  old CSR value
resp_err  out  1  1 = illegal op (or privilege fault); no CSR access performed
flush  in  1  exception/interrupt taken; abort
current_plv  in  2  current privilege level from CSR file
csr_re  out  1  CSR read enable
csr_num  out  32  CSR number
csr_rvalue  in  32  CSR read data (combinational)
csr_we  out  4  byte write enables
csr_wmask  out  32  bit write mask
csr_wvalue  out  32  write data

Behaviour:
- Decided: reset reset, synchronous, active-high; clock clk.
- FSM states: IDLE, READ, WRITE, RESP. Reset -> IDLE. All outputs are 0 on reset and in IDLE, except req_ready.
- req_ready = (state==IDLE) && !flush. Accept = req_valid && req_ready. On accept, op, num, wdata and mask are latched. No combinational path from req_* to csr_* outputs.
- Accepted op==11: go to RESP with resp_err=1 and resp_rdata=0. No csr_re or csr_we is ever asserted.
- READ (exactly 1 cycle):
  - csr_re=1, csr_num={zeros, num_q}.
  - csr_rvalue is captured into rdata_q at the clock edge.
  - Next state is WRITE if op is CSRWR or CSRXCHG, otherwise RESP.
- WRITE (exactly 1 cycle):
  - csr_re=0, csr_num held, csr_we=4'hF, csr_wvalue=wdata_q.
  - csr_wmask=32'hFFFFFFFF for CSRWR; mask_q for CSRXCHG.
  - Next state is RESP.
- RESP: resp_valid=1, resp_rdata=rdata_q, resp_err=err_q. Stay until resp_ready; on handshake go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency, accept to resp_valid: CSRRD = 2 cycles, CSRWR/CSRXCHG = 3 cycles, illegal = 1 cycle.
- csr_we is never nonzero outside WRITE. csr_re is never 1 outside READ.
- flush, any state:
  - All csr_* and resp_* outputs are forced to 0 in that same cycle (combinational gate). A write coinciding with flush is never issued.
  - Next state is IDLE; latched data is discarded.
  - flush has priority over resp_ready and over req_valid.
- flush in RESP with resp_ready=1: response is dropped; WB must not commit it.
- reset mid-operation: IDLE next cycle, no further CSR access.

Optional Feature:
CSR_ACC_PRIV_CHK_EN
- Defined: on accept, if current_plv != REQ_PLV, the request is treated as illegal: resp_err=1, 1-cycle path to RESP, no CSR access. This check applies to all ops.
- Undefined: current_plv is ignored; only op==11 sets resp_err.

Test Plan:
1. CSRRD num=0x030, CSR file SAVE0=0x12345678 -> READ cycle csr_re=1, csr_num=0x30; 2 cycles after accept resp_valid=1, resp_rdata=0x12345678, csr_we=0 throughout.
2. CSRWR num=0x00C, wdata=0x1C000000, old EENTRY=0xBFC00000 -> WRITE cycle csr_we=4'hF, csr_wmask=0xFFFFFFFF, csr_wvalue=0x1C000000; resp_rdata=0xBFC00000; a following CSRRD returns 0x1C000000.
3. CSRXCHG num=0x000, wdata=0x7, mask=0x4, CRMD=0x3 -> csr_wmask=0x4, csr_wvalue=0x7; resp_rdata=0x3; CRMD becomes 0x7.
4. resp_ready held 0 for 5 cycles after CSRRD -> resp_valid and resp_rdata stable; req_ready=0; a pulsed req_valid is not accepted.
5. CSRWR with flush asserted during the WRITE cycle -> csr_we=0 that cycle, target CSR unchanged, no resp_valid, IDLE next cycle with req_ready=1.
6. op=11 -> resp_err=1 one cycle after accept, resp_rdata=0, no csr_re/csr_we. With CSR_ACC_PRIV_CHK_EN and current_plv=3, a CSRWR gives resp_err=1 and no write.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// Bundle for csr_access_ctrl: EX request / WB response handshakes, flush and privilege inputs, CSR-file port.
// slave = controller view, master = pipeline + CSR-file view.
interface csr_access_ctrl_if #(
  parameter int CSR_NUM_W = 14
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [CSR_NUM_W-1:0] req_num;
  logic [31:0]          req_wdata;
  logic [31:0]          req_wmask;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_err;

  logic                 flush;
  logic [1:0]           current_plv;

  logic                 csr_re;
  logic [31:0]          csr_num;
  logic [31:0]          csr_rvalue;
  logic [3:0]           csr_we;
  logic [31:0]          csr_wmask;
  logic [31:0]          csr_wvalue;

  modport slave (
    input  req_valid, req_op, req_num, req_wdata, req_wmask,
    input  resp_ready, flush, current_plv, csr_rvalue,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue
  );

  modport master (
    output req_valid, req_op, req_num, req_wdata, req_wmask,
    output resp_ready, flush, current_plv, csr_rvalue,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: accept CSRRD/CSRWR/CSRXCHG, 1-cycle read then optional masked write, return old value.
// Optional privilege check enabled by defining CSR_ACC_PRIV_CHK_EN.
module csr_access_ctrl #(
  parameter int         CSR_NUM_W = 14,
  parameter logic [1:0] REQ_PLV   = 2'd0
) (
  input logic               clk,
  input logic               reset,
  csr_access_ctrl_if.slave  io_csr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [CSR_NUM_W-1:0] r_num;
  logic [31:0]          r_wdata;
  logic [31:0]          r_mask;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_illegal;
  logic [31:0]          w_num_ext;
  logic                 w_resp_valid;
  logic [31:0]          w_resp_rdata;
  logic                 w_resp_err;
  logic                 w_csr_re;
  logic [31:0]          w_csr_num;
  logic [3:0]           w_csr_we;
  logic [31:0]          w_csr_wmask;
  logic [31:0]          w_csr_wvalue;

`ifdef CSR_ACC_PRIV_CHK_EN
  assign w_illegal = (io_csr.req_op == OP_ILL) || (io_csr.current_plv != REQ_PLV);
`else
  logic w_unused_plv;
  assign w_unused_plv = ^{io_csr.current_plv, REQ_PLV};
  assign w_illegal    = (io_csr.req_op == OP_ILL);
`endif

  assign w_accept  = io_csr.req_valid && w_req_ready;
  assign w_num_ext = {{(32 - CSR_NUM_W){1'b0}}, r_num};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_num   <= '0;
      r_wdata <= 32'h0;
      r_mask  <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op    <= io_csr.req_op;
        r_num   <= io_csr.req_num;
        r_wdata <= io_csr.req_wdata;
        r_mask  <= io_csr.req_wmask;
        r_rdata <= 32'h0;
        r_err   <= w_illegal;
      end
      if ((r_state == S_READ) && !io_csr.flush) begin
        r_rdata <= io_csr.csr_rvalue;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_rdata = 32'h0;
    w_resp_err   = 1'b0;
    w_csr_re     = 1'b0;
    w_csr_num    = 32'h0;
    w_csr_we     = 4'h0;
    w_csr_wmask  = 32'h0;
    w_csr_wvalue = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (io_csr.req_valid) begin
          w_next = w_illegal ? S_RESP : S_READ;
        end
      end
      S_READ: begin
        w_csr_re  = 1'b1;
        w_csr_num = w_num_ext;
        w_next    = (r_op == OP_RD) ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        w_csr_num    = w_num_ext;
        w_csr_we     = 4'hF;
        w_csr_wmask  = (r_op == OP_WR) ? 32'hFFFF_FFFF : r_mask;
        w_csr_wvalue = r_wdata;
        w_next       = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        w_resp_rdata = r_rdata;
        w_resp_err   = r_err;
        if (io_csr.resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Flush wins over everything: no CSR side effect and no response may escape this cycle.
    if (io_csr.flush) begin
      w_next       = S_IDLE;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      w_resp_rdata = 32'h0;
      w_resp_err   = 1'b0;
      w_csr_re     = 1'b0;
      w_csr_num    = 32'h0;
      w_csr_we     = 4'h0;
      w_csr_wmask  = 32'h0;
      w_csr_wvalue = 32'h0;
    end
  end

  assign io_csr.req_ready  = w_req_ready;
  assign io_csr.resp_valid = w_resp_valid;
  assign io_csr.resp_rdata = w_resp_rdata;
  assign io_csr.resp_err   = w_resp_err;
  assign io_csr.csr_re     = w_csr_re;
  assign io_csr.csr_num    = w_csr_num;
  assign io_csr.csr_we     = w_csr_we;
  assign io_csr.csr_wmask  = w_csr_wmask;
  assign io_csr.csr_wvalue = w_csr_wvalue;

endmodule
